// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator: per-channel integrators, a shared comb stage, and an output FIFO.
// Latency: 2 edges from the frame-end sample to out_valid when the FIFO is empty.
// Backpressure: input is always accepted; a result that finds the FIFO full with no pop is dropped and sets overflow.
module cic_decimator_mc #(
    parameter int INPUT_WIDTH  = 5,
    parameter int OUTPUT_WIDTH = 32,
    parameter int NUM_STAGES   = 4,
    parameter int NUM_CH       = 2,
    parameter int MAX_DEC      = 64,
    parameter int DEFAULT_DEC  = 64,
    parameter int FIFO_DEPTH   = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DEC_W = $clog2(MAX_DEC) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DEC_W-1:0]               cfg_dec,
    input  logic                           cfg_load,
    input  logic                           in_valid,
    input  logic [CH_W-1:0]                in_chan,
    input  logic signed [INPUT_WIDTH-1:0]  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH_W-1:0]                out_chan,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           overflow
);
    // Internal width carries full CIC bit growth; integrators wrap modulo 2^IW by design.
    localparam int IW   = INPUT_WIDTH + NUM_STAGES * $clog2(MAX_DEC);
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [DEC_W-1:0] DEC_MIN = DEC_W'(2);
    localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(MAX_DEC);
    localparam logic [DEC_W-1:0] DEC_RST = DEC_W'(DEFAULT_DEC);

    // State
    logic [DEC_W-1:0]     dec_q;
    logic [IW-1:0]        integ_q [NUM_CH][NUM_STAGES];
    logic [DEC_W-1:0]     cnt_q   [NUM_CH];
    logic [IW-1:0]        dly_q   [NUM_CH][NUM_STAGES];
    logic                 comb_go_q;
    logic [IW-1:0]        comb_in_q;
    logic [CH_W-1:0]      comb_ch_q;
    logic [OUTPUT_WIDTH-1:0] fifo_dat_q [FIFO_DEPTH];
    logic [CH_W-1:0]      fifo_ch_q  [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        fill_q;
    logic                 overflow_q;

    // Next-state / combinational helpers
    logic [DEC_W-1:0]     dec_d;
    logic                 in_acc;
    logic                 frame_end;
    logic [IW-1:0]        integ_d [NUM_STAGES];
    logic [IW-1:0]        comb_stage_in [NUM_STAGES];
    logic [IW-1:0]        comb_res;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;

    // Clamp the requested ratio into the supported range 2..MAX_DEC.
    always_comb begin
        dec_d = cfg_dec;
        if (cfg_dec < DEC_MIN) dec_d = DEC_MIN;
        else if (cfg_dec > DEC_MAX) dec_d = DEC_MAX;
    end

    // A sample counts only when no soft-clear is happening and its channel tag exists.
    assign in_acc    = in_valid && !cfg_load && (int'(in_chan) < NUM_CH);
    assign frame_end = in_acc && (cnt_q[in_chan] == dec_q - DEC_W'(1));

    // Integrator cascade for the addressed channel: each stage adds the new value of the stage before.
    always_comb begin
        logic [IW-1:0] acc;
        acc = IW'($signed(in_data));
        for (int k = 0; k < NUM_STAGES; k++) begin
            acc        = integ_q[in_chan][k] + acc;
            integ_d[k] = acc;
        end
    end

    // Comb cascade for the channel latched at frame end, using that channel's delay registers.
    always_comb begin
        logic [IW-1:0] c;
        c = comb_in_q;
        for (int k = 0; k < NUM_STAGES; k++) begin
            comb_stage_in[k] = c;
            c = c - dly_q[comb_ch_q][k];
        end
        comb_res = c;
    end

    // Decimation ratio register: reloaded only by cfg_load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_q <= DEC_RST;
        else if (cfg_load) dec_q <= dec_d;
    end

    // Per-channel integrators and frame counters; frame end hands the last stage to the comb input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                for (int k = 0; k < NUM_STAGES; k++) integ_q[c][k] <= '0;
            end
            comb_go_q <= 1'b0;
            comb_in_q <= '0;
            comb_ch_q <= '0;
        end else if (cfg_load) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                for (int k = 0; k < NUM_STAGES; k++) integ_q[c][k] <= '0;
            end
            comb_go_q <= 1'b0;
        end else begin
            comb_go_q <= frame_end;
            if (in_acc) begin
                for (int k = 0; k < NUM_STAGES; k++) integ_q[in_chan][k] <= integ_d[k];
                cnt_q[in_chan] <= frame_end ? '0 : cnt_q[in_chan] + DEC_W'(1);
            end
            if (frame_end) begin
                comb_in_q <= integ_d[NUM_STAGES-1];
                comb_ch_q <= in_chan;
            end
        end
    end

    // Comb delay registers advance once per completed frame of their channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < NUM_STAGES; k++) dly_q[c][k] <= '0;
        end else if (cfg_load) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < NUM_STAGES; k++) dly_q[c][k] <= '0;
        end else if (comb_go_q) begin
            for (int k = 0; k < NUM_STAGES; k++) dly_q[comb_ch_q][k] <= comb_stage_in[k];
        end
    end

    assign fifo_full = (fill_q == CW'(FIFO_DEPTH));
    assign out_valid = (fill_q != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = comb_go_q && (!fifo_full || pop);

    // Output FIFO: a full FIFO still accepts a push when the head leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dat_q[i] <= '0;
                fifo_ch_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else if (cfg_load) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_dat_q[wr_ptr_q] <= OUTPUT_WIDTH'($signed(comb_res));
                fifo_ch_q[wr_ptr_q]  <= comb_ch_q;
                wr_ptr_q             <= (int'(wr_ptr_q) == FIFO_DEPTH - 1) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (int'(rd_ptr_q) == FIFO_DEPTH - 1) ? '0 : rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop)      fill_q <= fill_q + CW'(1);
            else if (!push_ok && pop) fill_q <= fill_q - CW'(1);
            if (comb_go_q && !push_ok) overflow_q <= 1'b1;
        end
    end

    // Head entry is presented only while valid so idle outputs read as zero.
    assign out_data = out_valid ? $signed(fifo_dat_q[rd_ptr_q]) : '0;
    assign out_chan = out_valid ? fifo_ch_q[rd_ptr_q] : '0;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cic_decimator_mc.sv
module tb_cic_decimator_mc;
    logic               clk = 1'b0;
    logic               rst_n;
    logic [6:0]         cfg_dec;
    logic               cfg_load;
    logic               in_valid;
    logic [0:0]         in_chan;
    logic signed [4:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [0:0]         out_chan;
    logic signed [31:0] out_data;
    logic               overflow;

    int n_chk  = 0;
    int n_fail = 0;
    longint q_dat[$];
    longint q_ch[$];

    localparam longint NONE = 64'sh7fff_0000_dead_beef;

    cic_decimator_mc dut (
        .clk(clk), .rst_n(rst_n), .cfg_dec(cfg_dec), .cfg_load(cfg_load),
        .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_data(out_data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record every accepted output word, sampled mid-cycle before the popping edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_dat.push_back(longint'(out_data));
            q_ch.push_back(longint'(out_chan));
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint dat_at(input int i);
        if (i < q_dat.size()) return q_dat[i];
        return NONE;
    endfunction

    function automatic longint ch_at(input int i);
        if (i < q_ch.size()) return q_ch[i];
        return NONE;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic signed [4:0] d);
        in_valid = 1'b1;
        in_chan  = ch;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [6:0] r);
        cfg_dec  = r;
        cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
        q_dat.delete();
        q_ch.delete();
    endtask

    initial begin
        rst_n = 1'b0; cfg_dec = '0; cfg_load = 1'b0; in_valid = 1'b0;
        in_chan = '0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_data", longint'(out_data), 0);
        chk("rst_chan", longint'(out_chan), 0);
        chk("rst_ovf", longint'(overflow), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Default R=64: 63 samples give nothing, the 64th gives C(67,4)
        for (int i = 0; i < 63; i++) send(0, 5'sd1);
        tick(3);
        chk("def_none", longint'(q_dat.size()), 0);
        send(0, 5'sd1);
        tick(3);
        chk("def_cnt", longint'(q_dat.size()), 1);
        chk("def_val", dat_at(0), 766480);

        // R=8 DC +1: steady value 8^4
        load(7'd8);
        for (int i = 0; i < 48; i++) send(0, 5'sd1);
        tick(4);
        chk("r8_cnt", longint'(q_dat.size()), 6);
        chk("r8_out5", dat_at(4), 4096);
        chk("r8_out6", dat_at(5), 4096);
        chk("r8_chan", ch_at(5), 0);

        // cfg_dec=100 clamps to 64: extremes +15 and -16
        load(7'd100);
        for (int i = 0; i < 320; i++) send(0, 5'sd15);
        tick(4);
        chk("p15_cnt", longint'(q_dat.size()), 5);
        chk("p15_out5", dat_at(4), 251658240);
        load(7'd64);
        for (int i = 0; i < 320; i++) send(0, -5'sd16);
        tick(4);
        chk("m16_cnt", longint'(q_dat.size()), 5);
        chk("m16_out5", dat_at(4), -268435456);

        // Two channels, R=4, ch0=+1 / ch1=-1 interleaved
        load(7'd4);
        for (int i = 0; i < 24; i++) begin
            send(0, 5'sd1);
            send(1, -5'sd1);
        end
        tick(4);
        chk("ch2_cnt", longint'(q_dat.size()), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("ch2_tag%0d", i), ch_at(i), i % 2);
        chk("ch2_d8", dat_at(8), 256);
        chk("ch2_d9", dat_at(9), -256);
        chk("ch2_d10", dat_at(10), 256);
        chk("ch2_d11", dat_at(11), -256);

        // cfg_dec=0 -> R=2; latency of exactly two edges; then steady 16
        load(7'd0);
        send(0, 5'sd1);
        send(0, 5'sd1);
        chk("lat_T", longint'(out_valid), 0);
        tick(1);
        chk("lat_T1", longint'(out_valid), 1);
        chk("lat_val", longint'(out_data), 5);
        for (int i = 0; i < 8; i++) send(0, 5'sd1);
        tick(4);
        chk("r2_cnt", longint'(q_dat.size()), 5);
        chk("r2_out5", dat_at(4), 16);

        // Overflow: 5 frame ends into a 4-deep FIFO with out_ready low
        load(7'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(0, 5'sd1);
        tick(3);
        chk("ovf_valid", longint'(out_valid), 1);
        chk("ovf_flag", longint'(overflow), 1);
        out_ready = 1'b1;
        tick(6);
        chk("ovf_cnt", longint'(q_dat.size()), 4);
        chk("ovf_d0", dat_at(0), 5);
        chk("ovf_d1", dat_at(1), 15);
        chk("ovf_d2", dat_at(2), 16);
        chk("ovf_d3", dat_at(3), 16);
        chk("ovf_empty", longint'(out_valid), 0);
        chk("ovf_sticky", longint'(overflow), 1);
        load(7'd2);
        chk("ovf_clr", longint'(overflow), 0);

        // cfg_load mid-frame: coincident sample discarded, next output after exactly R new samples
        load(7'd4);
        send(0, 5'sd1);
        send(0, 5'sd1);
        in_valid = 1'b1; in_chan = '0; in_data = 5'sd1;
        load(7'd4);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 5'sd1);
        tick(3);
        chk("mid_none", longint'(q_dat.size()), 0);
        send(0, 5'sd1);
        tick(3);
        chk("mid_cnt", longint'(q_dat.size()), 1);
        chk("mid_val", dat_at(0), 35);

        // Async reset with a result waiting in the FIFO
        load(7'd2);
        out_ready = 1'b0;
        send(0, 5'sd1);
        send(0, 5'sd1);
        send(0, 5'sd1);
        tick(1);
        chk("pre_rst_valid", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", longint'(out_valid), 0);
        chk("arst_data", longint'(out_data), 0);
        chk("arst_chan", longint'(out_chan), 0);
        chk("arst_ovf", longint'(overflow), 0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
